wb_arbiter2: RTL and testbench

- Two-master round-robin Wishbone arbiter that shares one slave port between two requesters.
- Typical uses: the CPU data bus plus a DMA or blitter master sharing the SDRAM cache port or a VGA framebuffer port.
- Ownership is held for the whole bus cycle (cyc).
- A watchdog terminates slave accesses that never ack, so a dead slave cannot hang either master.

---
 rtl/wb_arbiter2_if.sv | 18 +
 rtl/wb_arbiter2.sv | 125 ++++++++++++
 tb/tb_wb_arbiter2.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// rtl/wb_arbiter2_if.sv - Wishbone bus bundle shared by requesters and the downstream slave port
// dat_w carries master-to-slave write data, dat_r carries slave-to-master read data.
interface if_wb #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [AWIDTH-1:0]     adr;
  logic [DWIDTH/8-1:0]   sel;
  logic [DWIDTH-1:0]     dat_w;
  logic [DWIDTH-1:0]     dat_r;
  logic                  ack;

  modport master (output cyc, stb, we, adr, sel, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, sel, dat_w, output dat_r, ack);
endinterface

// File: rtl/wb_arbiter2.sv
// rtl/wb_arbiter2.sv - two-master round-robin Wishbone arbiter with stall watchdog
// Ownership is held for a whole bus cycle; a watchdog aborts accesses a dead slave never acks.
module wb_arbiter2 #(
  parameter int AWIDTH  = 32,
  parameter int DWIDTH  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  if_wb.slave        bus0,
  if_wb.slave        bus1,
  if_wb.master       sbus,
  output logic [1:0] owner,
  output logic       timeout
);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, GRANT0, GRANT1, ABORT0, ABORT1} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] wdog_q, wdog_d;

  logic req0, req1, sel1, own_cyc, own_stb, other_req;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    req0      = bus0.cyc & bus0.stb;
    req1      = bus1.cyc & bus1.stb;
    sel1      = (state_q == GRANT1) || (state_q == ABORT1);
    own_cyc   = sel1 ? bus1.cyc : bus0.cyc;
    own_stb   = sel1 ? bus1.stb : bus0.stb;
    other_req = sel1 ? req0 : req1;
    state_d   = state_q;
    last_d    = last_q;
    wdog_d    = '0;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? GRANT0 : GRANT1;
        else if (req0)     state_d = GRANT0;
        else if (req1)     state_d = GRANT1;
      end
      GRANT0, GRANT1: begin
        // Expiry wins over release so a stalled access always ends with an ack.
        if (own_cyc && own_stb && !sbus.ack) begin
          if (wdog_q == TMAX) begin
            state_d = sel1 ? ABORT1 : ABORT0;
            last_d  = sel1;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end else if (!own_cyc) begin
          last_d  = sel1;
          state_d = other_req ? (sel1 ? GRANT0 : GRANT1) : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sbus.cyc   = 1'b0;
    sbus.stb   = 1'b0;
    sbus.we    = 1'b0;
    sbus.adr   = {AWIDTH{1'b0}};
    sbus.sel   = '0;
    sbus.dat_w = {DWIDTH{1'b0}};
    bus0.ack   = 1'b0;
    bus0.dat_r = '0;
    bus1.ack   = 1'b0;
    bus1.dat_r = '0;
    owner      = 2'b00;
    timeout    = 1'b0;
    case (state_q)
      GRANT0: begin
        owner      = 2'b01;
        sbus.cyc   = bus0.cyc;
        sbus.stb   = bus0.stb;
        sbus.we    = bus0.we;
        sbus.adr   = bus0.adr;
        sbus.sel   = bus0.sel;
        sbus.dat_w = bus0.dat_w;
        bus0.ack   = sbus.ack;
        bus0.dat_r = sbus.dat_r;
      end
      GRANT1: begin
        owner      = 2'b10;
        sbus.cyc   = bus1.cyc;
        sbus.stb   = bus1.stb;
        sbus.we    = bus1.we;
        sbus.adr   = bus1.adr;
        sbus.sel   = bus1.sel;
        sbus.dat_w = bus1.dat_w;
        bus1.ack   = sbus.ack;
        bus1.dat_r = sbus.dat_r;
      end
      // Abort cycle: the slave port stays idle and any late slave ack is dropped.
      ABORT0: begin
        owner      = 2'b01;
        timeout    = 1'b1;
        bus0.ack   = 1'b1;
        bus0.dat_r = {DWIDTH{1'b1}};
      end
      ABORT1: begin
        owner      = 2'b10;
        timeout    = 1'b1;
        bus1.ack   = 1'b1;
        bus1.dat_r = {DWIDTH{1'b1}};
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb/tb_wb_arbiter2.sv - directed self-checking bench for wb_arbiter2
// Inputs change 2 time units after a rising edge; outputs are sampled 1 unit later.
module tb_wb_arbiter2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] owner;
  logic       timeout;
  int         n_checks = 0;
  int         n_errors = 0;

  if_wb #(.AWIDTH(32), .DWIDTH(32)) b0 ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) b1 ();
  if_wb #(.AWIDTH(32), .DWIDTH(32)) sb ();

  wb_arbiter2 #(.AWIDTH(32), .DWIDTH(32), .TIMEOUT(8)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus0    (b0),
    .bus1    (b1),
    .sbus    (sb),
    .owner   (owner),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic m0(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    b0.cyc = c; b0.stb = s; b0.we = w; b0.adr = a; b0.dat_w = d; b0.sel = 4'hF;
  endtask

  task automatic m1(input logic c, input logic s, input logic w, input logic [31:0] a, input logic [31:0] d);
    b1.cyc = c; b1.stb = s; b1.we = w; b1.adr = a; b1.dat_w = d; b1.sel = 4'hF;
  endtask

  initial begin
    m0(0, 0, 0, 0, 0);
    m1(0, 0, 0, 0, 0);
    sb.ack = 0; sb.dat_r = 32'hA5A5_0000;
    step(); step();
    rst = 1'b0;
    settle();
    check("rst_owner", owner, 2'b00);
    check("rst_timeout", timeout, 1'b0);
    check("rst_scyc", sb.cyc, 1'b0);
    check("rst_sadr", sb.adr, 32'h0);
    check("rst_ack0", b0.ack, 1'b0);

    // 1: single master write, slave acks two cycles after grant
    m0(1, 1, 1, 32'h40, 32'h1234_5678);
    settle();
    check("t1_pre_owner", owner, 2'b00);
    check("t1_pre_scyc", sb.cyc, 1'b0);
    step(); settle();
    check("t1_owner", owner, 2'b01);
    check("t1_scyc", sb.cyc, 1'b1);
    check("t1_sadr", sb.adr, 32'h40);
    check("t1_sdat", sb.dat_w, 32'h1234_5678);
    check("t1_ssel", sb.sel, 4'hF);
    check("t1_swe", sb.we, 1'b1);
    check("t1_ack_wait", b0.ack, 1'b0);
    step(); settle();
    check("t1_ack_wait2", b0.ack, 1'b0);
    step();
    sb.ack = 1; settle();
    check("t1_ack", b0.ack, 1'b1);
    check("t1_ack1_quiet", b1.ack, 1'b0);
    step();
    sb.ack = 0; m0(0, 0, 0, 0, 0); settle();
    check("t1_ack_once", b0.ack, 1'b0);
    step(); settle();
    check("t1_release", owner, 2'b00);

    // 2: tie after reset goes to bus0, then handover without idle, then alternation
    rst = 1'b1; step(); rst = 1'b0;
    m0(1, 1, 0, 32'hA0, 0);
    m1(1, 1, 0, 32'hB0, 0);
    step(); settle();
    check("t2_first", owner, 2'b01);
    check("t2_sadr0", sb.adr, 32'hA0);
    sb.ack = 1; settle();
    check("t2_ack0", b0.ack, 1'b1);
    check("t2_ack1_blocked", b1.ack, 1'b0);
    step();
    sb.ack = 0; m0(0, 0, 0, 0, 0); settle();
    step(); settle();
    check("t2_handover", owner, 2'b10);
    check("t2_sadr1", sb.adr, 32'hB0);
    m1(0, 0, 0, 0, 0);
    step(); settle();
    check("t2_idle_a", owner, 2'b00);
    m0(1, 1, 0, 32'hA4, 0); m1(1, 1, 0, 32'hB4, 0);
    step(); settle();
    check("t2_tie_b", owner, 2'b01);
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    step(); settle();
    check("t2_idle_b", owner, 2'b00);
    m0(1, 1, 0, 32'hA8, 0); m1(1, 1, 0, 32'hB8, 0);
    step(); settle();
    check("t2_tie_c", owner, 2'b10);
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    step(); settle();

    // 3: bus0 holds cyc across four beats while bus1 waits (last = 1 -> bus0 wins tie)
    m0(1, 1, 1, 32'hC0, 32'h1111_0000);
    m1(1, 1, 1, 32'hD0, 32'h2222_0000);
    step(); settle();
    check("t3_grant", owner, 2'b01);
    for (int i = 0; i < 4; i++) begin
      b0.adr = 32'hC0 + 32'(4 * i);
      sb.ack = 1; settle();
      check($sformatf("t3_owner_%0d", i), owner, 2'b01);
      check($sformatf("t3_sadr_%0d", i), sb.adr, 32'hC0 + 32'(4 * i));
      check($sformatf("t3_ack0_%0d", i), b0.ack, 1'b1);
      check($sformatf("t3_ack1_%0d", i), b1.ack, 1'b0);
      step();
    end
    sb.ack = 0; m0(0, 0, 0, 0, 0); settle();
    step(); settle();
    check("t3_handover", owner, 2'b10);
    check("t3_sadr1", sb.adr, 32'hD0);
    m1(0, 0, 0, 0, 0);
    step(); settle();

    // 4: bus1 read never acked -> abort after exactly 8 stalled cycles
    m1(1, 1, 0, 32'hE0, 0);
    step(); settle();
    check("t4_grant", owner, 2'b10);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) m0(1, 1, 0, 32'hF0, 0);
      settle();
      check($sformatf("t4_stall_cyc_%0d", i), sb.cyc, 1'b1);
      check($sformatf("t4_stall_ack_%0d", i), b1.ack, 1'b0);
      check($sformatf("t4_stall_to_%0d", i), timeout, 1'b0);
      step();
    end
    settle();
    check("t4_abort_ack", b1.ack, 1'b1);
    check("t4_abort_dat", b1.dat_r, 32'hFFFF_FFFF);
    check("t4_timeout", timeout, 1'b1);
    check("t4_abort_scyc", sb.cyc, 1'b0);
    check("t4_abort_ack0", b0.ack, 1'b0);
    // 5: a late slave ack during the abort cycle must be swallowed
    sb.ack = 1; sb.dat_r = 32'h5555_5555; m1(0, 0, 0, 0, 0); settle();
    check("t5_late_dat", b1.dat_r, 32'hFFFF_FFFF);
    check("t5_late_sstb", sb.stb, 1'b0);
    step();
    sb.ack = 0; settle();
    check("t5_no_second_ack", b1.ack, 1'b0);
    check("t4_timeout_pulse", timeout, 1'b0);
    check("t4_gap_scyc", sb.cyc, 1'b0);
    check("t4_gap_owner", owner, 2'b00);
    step(); settle();
    check("t4_pending_grant", owner, 2'b01);
    check("t4_pending_sadr", sb.adr, 32'hF0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_wdog_fresh_%0d", i), timeout, 1'b0);
      step(); settle();
    end
    check("t5_wdog_expire", timeout, 1'b1);
    check("t5_wdog_ack0", b0.ack, 1'b1);
    m0(0, 0, 0, 0, 0);
    step(); step(); settle();
    check("t5_idle", owner, 2'b00);

    // 6: asynchronous reset mid-burst while bus1 owns the bus
    m1(1, 1, 1, 32'h100, 32'hBEEF);
    step(); settle();
    check("t6_grant", owner, 2'b10);
    sb.ack = 1; settle();
    check("t6_ack_live", b1.ack, 1'b1);
    rst = 1'b1; settle();
    check("t6_rst_owner", owner, 2'b00);
    check("t6_rst_scyc", sb.cyc, 1'b0);
    check("t6_rst_ack1", b1.ack, 1'b0);
    check("t6_rst_ack0", b0.ack, 1'b0);
    sb.ack = 0;
    m0(1, 1, 0, 32'h200, 0);
    rst = 1'b0;
    step(); settle();
    check("t6_tie_after_rst", owner, 2'b01);
    m0(0, 0, 0, 0, 0); m1(0, 0, 0, 0, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
